// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel AXI4-Lite register bank: register
// byte offsets, STATUS bit positions, AXI response codes, channel FSM
// states and the NSAMP reset value.
package goertzel_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_COEF   = 8'h04;
  localparam logic [7:0] OFF_NSAMP  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RES_RE = 8'h10;
  localparam logic [7:0] OFF_RES_IM = 8'h14;
  localparam logic [7:0] OFF_ID     = 8'h18;
  localparam logic [7:0] OFF_IRQ_EN = 8'h1C;

  localparam int CTRL_START = 0;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] NSAMP_RST = 16'd205;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_latch.sv
// Write-channel front end: accepts AW and W independently, holds whichever
// arrives first, and raises wr_go in the cycle both halves are available
// (held or handshaking now). The selected address/data are valid with wr_go.
module axil_wr_latch (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        accept,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        wr_go,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);

  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_now;
  logic        w_now;

  assign awready = accept & ~aw_held;
  assign wready  = accept & ~w_held;
  assign aw_now  = awvalid & awready;
  assign w_now   = wvalid & wready;
  assign wr_go   = accept & (aw_held | aw_now) & (w_held | w_now);
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held  ? w_data_q  : wdata;
  assign wr_strb = w_held  ? w_strb_q  : wstrb;

  // Hold each half until the joined write fires, then release both.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge values.
    if (!axi_rstn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (wr_go) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_now) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_now) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/goertzel_axil_regs.sv
// AXI4-Lite register bank for the Goertzel engine (CTRL, COEF, NSAMP,
// STATUS, RES_RE, RES_IM, ID). Independent single-outstanding write and
// read channels. Define GOERTZEL_AXIL_REGS_IRQ_EN to add the IRQ_EN
// register at 0x1C and the registered irq output.
module goertzel_axil_regs
  import goertzel_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          COEF_W  = 18,
  parameter int          NSAMP_W = 16,
  parameter int          RES_W   = 32,
  parameter logic [31:0] ID_VAL  = 32'h4752_0001
) (
  input  logic               axi_clk,
  input  logic               axi_rstn,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [31:0]        axi_awaddr,
  input  logic [2:0]         axi_awprot,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  input  logic [31:0]        axi_wdata,
  input  logic [3:0]         axi_wstrb,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  output logic [1:0]         axi_bresp,
  input  logic               axi_arvalid,
  output logic               axi_arready,
  input  logic [31:0]        axi_araddr,
  input  logic [2:0]         axi_arprot,
  output logic               axi_rvalid,
  input  logic               axi_rready,
  output logic [31:0]        axi_rdata,
  output logic [1:0]         axi_rresp,
  output logic               eng_start,
  output logic [COEF_W-1:0]  eng_coef,
  output logic [NSAMP_W-1:0] eng_nsamp,
  input  logic               eng_busy,
  input  logic               eng_done,
  input  logic [RES_W-1:0]   eng_res_re,
  input  logic [RES_W-1:0]   eng_res_im
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
  ,
  output logic               irq
`endif
);

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic               alive;
  logic [COEF_W-1:0]  coef_q;
  logic [NSAMP_W-1:0] nsamp_q;
  logic [RES_W-1:0]   res_re_q;
  logic [RES_W-1:0]   res_im_q;
  logic               done_q;
  logic               err_q;

  logic               wr_go;
  logic [31:0]        wr_addr;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strb;
  logic [ADDR_W-1:0]  wr_off;
  logic [ADDR_W-1:0]  rd_off;
  logic [1:0]         wr_resp;
  logic               do_start;
  logic               set_err;
  logic               we_coef;
  logic               we_nsamp;
  logic               we_status;
  logic               we_irq;
  logic               w1c_done;
  logic               w1c_err;
  logic [31:0]        rd_val;
  logic [1:0]         rd_resp;
  logic               unused_ok;

  assign eng_coef    = coef_q;
  assign eng_nsamp   = nsamp_q;
  assign axi_arready = alive & (rd_state == R_IDLE);
  assign unused_ok   = &{1'b0, axi_awprot, axi_arprot, wr_addr[31:ADDR_W], wr_addr[1:0],
                         axi_araddr[31:ADDR_W], axi_araddr[1:0]};

  axil_wr_latch u_wr_latch (
    .axi_clk  (axi_clk),
    .axi_rstn (axi_rstn),
    .accept   (alive & (wr_state == W_IDLE)),
    .awvalid  (axi_awvalid),
    .awaddr   (axi_awaddr),
    .awready  (axi_awready),
    .wvalid   (axi_wvalid),
    .wdata    (axi_wdata),
    .wstrb    (axi_wstrb),
    .wready   (axi_wready),
    .wr_go    (wr_go),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb)
  );

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) alive <= 1'b0;
    else           alive <= 1'b1;
  end

  // Decode the pending write into per-register enables and a response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_off    = {wr_addr[ADDR_W-1:2], 2'b00};
    wr_resp   = RESP_OKAY;
    do_start  = 1'b0;
    set_err   = 1'b0;
    we_coef   = 1'b0;
    we_nsamp  = 1'b0;
    we_status = 1'b0;
    we_irq    = 1'b0;
    case (wr_off)
      ADDR_W'(OFF_CTRL): begin
        if (wr_strb[0] && wr_data[CTRL_START]) begin
          if (eng_busy) begin
            set_err = 1'b1;
            wr_resp = RESP_SLVERR;
          end else begin
            do_start = 1'b1;
          end
        end
      end
      ADDR_W'(OFF_COEF):   we_coef   = 1'b1;
      ADDR_W'(OFF_NSAMP):  we_nsamp  = 1'b1;
      ADDR_W'(OFF_STATUS): we_status = 1'b1;
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
      ADDR_W'(OFF_IRQ_EN): we_irq    = 1'b1;
`endif
      default:             wr_resp   = RESP_SLVERR;
    endcase
    w1c_done = we_status & wr_strb[0] & wr_data[ST_DONE];
    w1c_err  = we_status & wr_strb[0] & wr_data[ST_ERR];
  end

  // Write response channel: raise bvalid with the write, hold until bready.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_state   <= W_IDLE;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: if (wr_go) begin
          axi_bvalid <= 1'b1;
          axi_bresp  <= wr_resp;
          wr_state   <= W_RESP;
        end
        W_RESP: if (axi_bready) begin
          axi_bvalid <= 1'b0;
          wr_state   <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Register file updates: configuration, start pulse, sticky flags, results.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      coef_q    <= '0;
      nsamp_q   <= NSAMP_W'(NSAMP_RST);
      eng_start <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      res_re_q  <= '0;
      res_im_q  <= '0;
    end else begin
      eng_start <= wr_go & do_start;
      if (wr_go && we_coef)  coef_q  <= COEF_W'(strb_merge(32'(coef_q), wr_data, wr_strb));
      if (wr_go && we_nsamp) nsamp_q <= NSAMP_W'(strb_merge(32'(nsamp_q), wr_data, wr_strb));
      // A completion in the same cycle as a clear leaves DONE set.
      if (eng_done)                              done_q <= 1'b1;
      else if (wr_go && (do_start || w1c_done))  done_q <= 1'b0;
      if (wr_go && set_err)      err_q <= 1'b1;
      else if (wr_go && w1c_err) err_q <= 1'b0;
      if (eng_done) begin
        res_re_q <= eng_res_re;
        res_im_q <= eng_res_im;
      end
    end
  end

`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
  logic irq_en_q;

  // Interrupt enable register and registered interrupt output.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_go && we_irq && wr_strb[0]) irq_en_q <= wr_data[0];
      irq <= done_q & irq_en_q;
    end
  end
`else
  logic irq_en_q;
  assign irq_en_q = 1'b0;
`endif

  // Decode the read address against the current (pre-update) register state.
  always_comb begin
    rd_off  = {axi_araddr[ADDR_W-1:2], 2'b00};
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_off)
      ADDR_W'(OFF_CTRL):   rd_val = '0;
      ADDR_W'(OFF_COEF):   rd_val = 32'(signed'(coef_q));
      ADDR_W'(OFF_NSAMP):  rd_val = 32'(nsamp_q);
      ADDR_W'(OFF_STATUS): begin
        rd_val[ST_BUSY] = eng_busy;
        rd_val[ST_DONE] = done_q;
        rd_val[ST_ERR]  = err_q;
      end
      ADDR_W'(OFF_RES_RE): rd_val = 32'(res_re_q);
      ADDR_W'(OFF_RES_IM): rd_val = 32'(res_im_q);
      ADDR_W'(OFF_ID):     rd_val = ID_VAL;
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
      ADDR_W'(OFF_IRQ_EN): rd_val = 32'(irq_en_q);
`endif
      default:             rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: register decoded data one cycle after AR, hold until rready.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_state   <= R_IDLE;
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (axi_arvalid && axi_arready) begin
          axi_rvalid <= 1'b1;
          axi_rdata  <= rd_val;
          axi_rresp  <= rd_resp;
          rd_state   <= R_DATA;
        end
        R_DATA: if (axi_rready) begin
          axi_rvalid <= 1'b0;
          rd_state   <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_axil_regs.sv
// Self-checking bench for goertzel_axil_regs: directed scenarios plus a
// randomized transaction mix checked against a behavioural register model.
module tb_goertzel_axil_regs;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        eng_start, eng_busy = 1'b0, eng_done = 1'b0;
  logic [17:0] eng_coef;
  logic [15:0] eng_nsamp;
  logic [31:0] eng_res_re = '0, eng_res_im = '0;
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  goertzel_axil_regs dut (
    .axi_clk(clk), .axi_rstn(rstn),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(3'b000),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(3'b000),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
    .eng_start(eng_start), .eng_coef(eng_coef), .eng_nsamp(eng_nsamp),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_res_re(eng_res_re), .eng_res_im(eng_res_im)
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
    , .irq(irq)
`endif
  );

  // ---------------- behavioural register model ----------------
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_t;

  logic [31:0] m_coef, m_nsamp, m_re, m_im;
  bit          m_done, m_err, m_irq_en;
  int          exp_starts = 0;

  function automatic void model_reset();
    m_coef = 0; m_nsamp = 205; m_re = 0; m_im = 0;
    m_done = 0; m_err = 0; m_irq_en = 0;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input bit busy);
    int word = int'(addr[7:2]);
    case (word)
      0: begin
        if (strb[0] && data[0]) begin
          if (busy) begin m_err = 1; return 2'b10; end
          exp_starts++; m_done = 0;
        end
        return 2'b00;
      end
      1: begin
        for (int i = 0; i < 4; i++) if (strb[i]) m_coef[8*i +: 8] = data[8*i +: 8];
        m_coef &= 32'h0003_FFFF;
        return 2'b00;
      end
      2: begin
        for (int i = 0; i < 4; i++) if (strb[i]) m_nsamp[8*i +: 8] = data[8*i +: 8];
        m_nsamp &= 32'h0000_FFFF;
        return 2'b00;
      end
      3: begin
        if (strb[0] && data[1]) m_done = 0;
        if (strb[0] && data[2]) m_err = 0;
        return 2'b00;
      end
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
      7: begin if (strb[0]) m_irq_en = data[0]; return 2'b00; end
`endif
      default: return 2'b10;
    endcase
  endfunction

  function automatic rd_t model_read(input logic [31:0] addr, input bit busy);
    rd_t r;
    int word = int'(addr[7:2]);
    r.data = 0; r.resp = 2'b00;
    case (word)
      0: r.data = 0;
      1: r.data = {{14{m_coef[17]}}, m_coef[17:0]};
      2: r.data = m_nsamp;
      3: r.data = {29'd0, m_err, m_done, busy};
      4: r.data = m_re;
      5: r.data = m_im;
      6: r.data = 32'h4752_0001;
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
      7: r.data = {31'd0, m_irq_en};
`endif
      default: r.resp = 2'b10;
    endcase
    return r;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_hs, w_hs;
    int n;
    @(negedge clk);
    awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) awvalid = 0;
      if (w_hs)  wvalid = 0;
    end
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", addr, bvalid);
      awvalid = 0; wvalid = 0; resp = 2'bxx;
    end else begin
      resp = bresp; bready = 1;
      @(negedge clk); bready = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      hs = arready;
      @(negedge clk); n++;
    end
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency addr=%h: rvalid=%b, required 1 one cycle after AR", addr, rvalid);
      data = 'x; resp = 2'bxx;
    end else begin
      data = rdata; resp = rresp; rready = 1;
      @(negedge clk); rready = 0;
    end
  endtask

  task automatic pulse_done(input logic [31:0] re, input logic [31:0] im);
    @(negedge clk);
    eng_done = 1; eng_res_re = re; eng_res_im = im;
    @(negedge clk);
    eng_done = 0;
    m_done = 1; m_re = re; m_im = im;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; rd_t m;
    logic [31:0] addrs [6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, eng_start} !== 6'b0 ||
        {bresp, rresp} !== 4'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/valid=%b%b%b%b%b start=%b bresp=%0d rresp=%0d rdata=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, eng_start, bresp, rresp, rdata);
    end
    checks++;
    if (eng_coef !== 18'h0 || eng_nsamp !== 16'd205) begin
      errors++;
      $display("FAIL reset_eng_cfg: coef=%h nsamp=%0d, required 0 / 205", eng_coef, eng_nsamp);
    end
    rstn = 1;
    repeat (2) @(negedge clk);
    foreach (addrs[i]) begin
      axi_read(addrs[i], d, r);
      m = model_read(addrs[i], eng_busy);
      checks++;
      if (d !== m.data || r !== m.resp) begin
        errors++;
        $display("FAIL reset_read %h: data=%h resp=%0d, required %h/%0d", addrs[i], d, r, m.data, m.resp);
      end
    end
  endtask

  task automatic test_coef_sext();
    logic [31:0] d; logic [1:0] r, er; rd_t m;
    logic [31:0] vals [2] = '{32'h0001_F2A3, 32'h0003_F2A3};
    foreach (vals[i]) begin
      axi_write(32'h04, vals[i], 4'hF, r);
      er = model_write(32'h04, vals[i], 4'hF, eng_busy);
      checks++;
      if (r !== er) begin errors++; $display("FAIL coef_bresp: got %0d, required %0d", r, er); end
      axi_read(32'h04, d, r);
      m = model_read(32'h04, eng_busy);
      checks++;
      if (d !== m.data || r !== m.resp) begin
        errors++;
        $display("FAIL coef_sext wrote %h: data=%h resp=%0d, required %h/%0d", vals[i], d, r, m.data, m.resp);
      end
    end
  endtask

  task automatic test_aw_lead();
    logic [31:0] d; logic [1:0] r, er; rd_t m;
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1; wvalid = 0;
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b0) begin
        errors++;
        $display("FAIL aw_lead_wait cycle %0d: bvalid=%b awready=%b, required 0/0", i, bvalid, awready);
      end
      @(negedge clk);
    end
    wdata = 32'h0000_1234; wstrb = 4'h3; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    er = model_write(32'h08, 32'h0000_1234, 4'h3, eng_busy);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== er) begin
        errors++;
        $display("FAIL aw_lead_bhold cycle %0d: bvalid=%b bresp=%0d, required 1/%0d", i, bvalid, bresp, er);
      end
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL aw_lead_bdrop: bvalid=%b, required 0", bvalid); end
    axi_read(32'h08, d, r);
    m = model_read(32'h08, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp) begin
      errors++;
      $display("FAIL aw_lead_nsamp: data=%h resp=%0d, required %h/%0d", d, r, m.data, m.resp);
    end
  endtask

  task automatic test_start_done();
    logic [31:0] d; logic [1:0] r, er; rd_t m;
    int s0;
    logic [31:0] addrs [3] = '{32'h0C, 32'h10, 32'h14};
    eng_busy = 0;
    s0 = start_cnt;
    axi_write(32'h00, 32'h1, 4'h1, r);
    er = model_write(32'h00, 32'h1, 4'h1, eng_busy);
    repeat (2) @(negedge clk);
    checks++;
    if (r !== er || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL start_pulse: bresp=%0d start_cycles=%0d, required %0d/1", r, start_cnt - s0, er);
    end
    pulse_done(32'h0000_0100, 32'hFFFF_FF00);
    foreach (addrs[i]) begin
      axi_read(addrs[i], d, r);
      m = model_read(addrs[i], eng_busy);
      checks++;
      if (d !== m.data || r !== m.resp) begin
        errors++;
        $display("FAIL done_read %h: data=%h resp=%0d, required %h/%0d", addrs[i], d, r, m.data, m.resp);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] d; logic [1:0] r, er; rd_t m;
    int s0;
    eng_busy = 1;
    s0 = start_cnt;
    axi_write(32'h00, 32'h1, 4'hF, r);
    er = model_write(32'h00, 32'h1, 4'hF, eng_busy);
    repeat (2) @(negedge clk);
    checks++;
    if (r !== er || start_cnt != s0) begin
      errors++;
      $display("FAIL busy_start: bresp=%0d starts=%0d, required %0d/0", r, start_cnt - s0, er);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        axi_write(32'h0C, 32'h6, 4'hF, r);
        er = model_write(32'h0C, 32'h6, 4'hF, eng_busy);
        checks++;
        if (r !== er) begin errors++; $display("FAIL w1c_bresp: got %0d, required %0d", r, er); end
      end
      axi_read(32'h0C, d, r);
      m = model_read(32'h0C, eng_busy);
      checks++;
      if (d !== m.data || r !== m.resp) begin
        errors++;
        $display("FAIL busy_status step %0d: data=%h resp=%0d, required %h/%0d", k, d, r, m.data, m.resp);
      end
    end
    eng_busy = 0;
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r, er; rd_t m;
    axi_read(32'h20, d, r);
    m = model_read(32'h20, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp) begin
      errors++; $display("FAIL unmapped_read: data=%h resp=%0d, required %h/%0d", d, r, m.data, m.resp);
    end
    axi_write(32'h18, 32'hDEAD_BEEF, 4'hF, r);
    er = model_write(32'h18, 32'hDEAD_BEEF, 4'hF, eng_busy);
    checks++;
    if (r !== er) begin errors++; $display("FAIL ro_write: bresp=%0d, required %0d", r, er); end
    axi_read(32'h18, d, r);
    m = model_read(32'h18, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp) begin
      errors++; $display("FAIL id_read: data=%h resp=%0d, required %h/%0d", d, r, m.data, m.resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r, rw, er; rd_t m;
    m = model_read(32'h04, eng_busy);
    fork
      axi_write(32'h04, 32'h0002_5555, 4'hF, rw);
      axi_read(32'h04, d, r);
    join
    er = model_write(32'h04, 32'h0002_5555, 4'hF, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp || rw !== er) begin
      errors++;
      $display("FAIL simultaneous: rdata=%h rresp=%0d bresp=%0d, required %h/%0d/%0d", d, r, rw, m.data, m.resp, er);
    end
    axi_read(32'h04, d, r);
    m = model_read(32'h04, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp) begin
      errors++; $display("FAIL simultaneous_after: data=%h resp=%0d, required %h/%0d", d, r, m.data, m.resp);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, addr, data; logic [1:0] r, er; logic [3:0] strb; rd_t m;
    int op;
    for (int i = 0; i < 80; i++) begin
      op   = int'($urandom_range(0, 9));
      addr = ($urandom() & 32'hFFFF_FF00) | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      data = $urandom();
      strb = 4'($urandom_range(0, 15));
      if (op <= 3) begin
        axi_write(addr, data, strb, r);
        er = model_write(addr, data, strb, eng_busy);
        @(negedge clk);
        checks++;
        if (r !== er || start_cnt != exp_starts) begin
          errors++;
          $display("FAIL rand_write %0d addr=%h: bresp=%0d starts=%0d, required %0d/%0d",
                   i, addr, r, start_cnt, er, exp_starts);
        end
      end else if (op <= 7) begin
        axi_read(addr, d, r);
        m = model_read(addr, eng_busy);
        checks++;
        if (d !== m.data || r !== m.resp) begin
          errors++;
          $display("FAIL rand_read %0d addr=%h: data=%h resp=%0d, required %h/%0d", i, addr, d, r, m.data, m.resp);
        end
      end else if (op == 8) begin
        pulse_done($urandom(), $urandom());
      end else begin
        @(negedge clk);
        eng_busy = ~eng_busy;
      end
    end
    eng_busy = 0;
    checks++;
    if (eng_coef !== m_coef[17:0] || eng_nsamp !== m_nsamp[15:0]) begin
      errors++;
      $display("FAIL rand_eng_cfg: coef=%h nsamp=%h, required %h/%h", eng_coef, eng_nsamp, m_coef[17:0], m_nsamp[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; rd_t m;
    int n;
    @(negedge clk);
    awaddr = 32'h08; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (bvalid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL reset_mid_setup: bvalid=%b, required 1", bvalid); end
    @(negedge clk);
    rstn = 0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || eng_nsamp !== 16'd205) begin
      errors++;
      $display("FAIL reset_mid_abort: bvalid=%b nsamp=%0d, required 0/205", bvalid, eng_nsamp);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk);
    axi_read(32'h08, d, r);
    m = model_read(32'h08, eng_busy);
    checks++;
    if (d !== m.data || r !== m.resp) begin
      errors++; $display("FAIL reset_mid_nsamp: data=%h resp=%0d, required %h/%0d", d, r, m.data, m.resp);
    end
  endtask

  task automatic test_irq();
    logic [1:0] r, er;
    axi_write(32'h1C, 32'h1, 4'hF, r);
    er = model_write(32'h1C, 32'h1, 4'hF, eng_busy);
    checks++;
    if (r !== er) begin errors++; $display("FAIL irq_en_bresp: got %0d, required %0d", r, er); end
`ifdef GOERTZEL_AXIL_REGS_IRQ_EN
    pulse_done(32'h1, 32'h2);
    @(negedge clk);
    checks++;
    if (irq !== (m_done & m_irq_en)) begin errors++; $display("FAIL irq_set: irq=%b, required %b", irq, m_done & m_irq_en); end
    axi_write(32'h0C, 32'h2, 4'h1, r);
    er = model_write(32'h0C, 32'h2, 4'h1, eng_busy);
    checks++;
    if (irq !== (m_done & m_irq_en)) begin errors++; $display("FAIL irq_clear: irq=%b, required %b", irq, m_done & m_irq_en); end
`endif
  endtask

  initial begin
    test_reset();
    test_coef_sext();
    test_aw_lead();
    test_start_done();
    test_busy_start();
    test_unmapped();
    test_back_to_back();
    test_irq();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
